// File: rtl/segment_counter_ctrl_if.sv
// Key/switch inputs and seven-segment display outputs of the segment counter.
interface segment_counter_ctrl_if;
   logic       key_run_n;
   logic       key_clr_n;
   logic       sw_dir;
   logic [8:0] segment_led_1;
   logic [8:0] segment_led_2;
   logic       wrap_pulse;

   modport master (
      output key_run_n, key_clr_n, sw_dir,
      input  segment_led_1, segment_led_2, wrap_pulse
   );

   modport slave (
      input  key_run_n, key_clr_n, sw_dir,
      output segment_led_1, segment_led_2, wrap_pulse
   );
endinterface

// File: rtl/segment_counter_ctrl.sv
// Two-digit BCD up/down counter with run/pause and clear pushbuttons,
// driving two seven-segment digits. Keys are synchronized and debounced;
// the count steps once per CNT_NUM clock cycles while running.
module segment_counter_ctrl #(
   parameter int CNT_NUM = 12_000_000,
   parameter int MAX_VAL = 99,
   parameter int DEB_NUM = 240_000
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   segment_counter_ctrl_if.slave  io
);

   localparam int               PRE_W     = $clog2(CNT_NUM);
   localparam int               DEB_W     = $clog2(DEB_NUM + 1);
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CNT_NUM - 1);
   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_NUM - 1);
   localparam logic [3:0]       MAX_TENS  = 4'(MAX_VAL / 10);
   localparam logic [3:0]       MAX_UNITS = 4'(MAX_VAL % 10);
   localparam int               KEY_RUN   = 0;
   localparam int               KEY_CLR   = 1;
   localparam int               DIR_BIT   = 2;

   typedef enum logic {ST_PAUSE = 1'b0, ST_RUN = 1'b1} run_state_t;

   // bit order {dir, clr, run}
   logic [2:0]       meta;
   logic [2:0]       sync;
   logic [1:0]       deb_level;
   logic [DEB_W-1:0] deb_cnt [2];
   logic [1:0]       press;
   run_state_t       state;
   run_state_t       state_next;
   logic             running;
   logic [PRE_W-1:0] pre;
   logic             tick;
   logic [3:0]       tens;
   logic [3:0]       units;
   logic             at_max;
   logic             at_zero;
   logic             wrap;
   logic [8:0]       seg_tens;
   logic [8:0]       seg_units;

   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      case (digit)
         4'd0:    seg_decode = 7'h3F;
         4'd1:    seg_decode = 7'h06;
         4'd2:    seg_decode = 7'h5B;
         4'd3:    seg_decode = 7'h4F;
         4'd4:    seg_decode = 7'h66;
         4'd5:    seg_decode = 7'h6D;
         4'd6:    seg_decode = 7'h7D;
         4'd7:    seg_decode = 7'h07;
         4'd8:    seg_decode = 7'h7F;
         4'd9:    seg_decode = 7'h6F;
         default: seg_decode = 7'h00;
      endcase
   endfunction

   // Two-flop synchronizers for the asynchronous keys and direction switch
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         meta <= 3'b111;
         sync <= 3'b111;
      end else begin
         meta <= {io.sw_dir, io.key_clr_n, io.key_run_n};
         sync <= meta;
      end
   end

   // Debounce: adopt a new key level only after it has differed DEB_NUM cycles in a row
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         deb_level  <= 2'b11;
         deb_cnt[0] <= '0;
         deb_cnt[1] <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (sync[k] == deb_level[k]) begin
               deb_cnt[k] <= '0;
            end else if (deb_cnt[k] == DEB_LAST) begin
               deb_level[k] <= sync[k];
               deb_cnt[k]   <= '0;
            end else begin
               deb_cnt[k] <= deb_cnt[k] + 1'b1;
            end
         end
      end
   end

   // A press is the single cycle in which a released key is accepted as pressed
   always_comb begin
      press = 2'b00;
      for (int k = 0; k < 2; k++) begin
         press[k] = deb_level[k] && !sync[k] && (deb_cnt[k] == DEB_LAST);
      end
   end

   // Run/pause state register; comes out of reset running
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Each run press flips between running and paused
   always_comb begin
      state_next = state;
      if (press[KEY_RUN]) begin
         state_next = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
      end
   end

   // Running flag gates the prescaler and lights the units decimal point
   always_comb begin
      running = (state == ST_RUN);
   end

   assign tick    = running && (pre == PRE_LAST);
   assign at_max  = (tens == MAX_TENS) && (units == MAX_UNITS);
   assign at_zero = (tens == 4'd0) && (units == 4'd0);

   // Prescaler: free-runs while running, holds while paused, restarts on clear
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pre <= '0;
      end else if (press[KEY_CLR] || tick) begin
         pre <= '0;
      end else if (running) begin
         pre <= pre + 1'b1;
      end
   end

   // BCD up/down count with wrap at 0 and MAX_VAL; a clear wins over a coincident tick
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tens  <= 4'd0;
         units <= 4'd0;
         wrap  <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (press[KEY_CLR]) begin
            tens  <= 4'd0;
            units <= 4'd0;
         end else if (tick) begin
            if (sync[DIR_BIT]) begin
               if (at_max) begin
                  tens  <= 4'd0;
                  units <= 4'd0;
                  wrap  <= 1'b1;
               end else if (units == 4'd9) begin
                  units <= 4'd0;
                  tens  <= tens + 4'd1;
               end else begin
                  units <= units + 4'd1;
               end
            end else begin
               if (at_zero) begin
                  tens  <= MAX_TENS;
                  units <= MAX_UNITS;
                  wrap  <= 1'b1;
               end else if (units == 4'd0) begin
                  units <= 4'd9;
                  tens  <= tens - 4'd1;
               end else begin
                  units <= units - 4'd1;
               end
            end
         end
      end
   end

   // Registered segment patterns: leading zero blanked, units DP shows running
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         seg_tens  <= 9'h000;
         seg_units <= 9'h0BF;
      end else begin
         seg_tens  <= {2'b00, (tens == 4'd0) ? 7'h00 : seg_decode(tens)};
         seg_units <= {1'b0, running, seg_decode(units)};
      end
   end

   assign io.segment_led_1 = seg_tens;
   assign io.segment_led_2 = seg_units;
   assign io.wrap_pulse    = wrap;

endmodule

// File: tb/tb_segment_counter_ctrl.sv
// Bench for segment_counter_ctrl with short periods (CNT_NUM=4, DEB_NUM=3, MAX_VAL=12).
module tb_segment_counter_ctrl;

   localparam int CNT  = 4;
   localparam int DEB  = 3;
   localparam int MAXV = 12;

   logic clk_in   = 1'b0;
   logic rst_n_in = 1'b0;

   segment_counter_ctrl_if io ();

   segment_counter_ctrl #(
      .CNT_NUM (CNT),
      .MAX_VAL (MAXV),
      .DEB_NUM (DEB)
   ) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .io       (io)
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;
   int wrap_seen = 0;

   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   typedef struct {
      logic [2:0] meta;
      logic [2:0] sync;
      logic [1:0] lvl;
      int         len0;
      int         len1;
      bit         running;
      int         phase;
      int         count;
      logic [8:0] e1;
      logic [8:0] e2;
      logic       ew;
   } model_t;

   model_t     m;
   logic [18:0] sb [$];

   typedef struct {
      logic       dir;
      int         target;
      logic [8:0] led1;
      logic [8:0] led2;
      int         wraps;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // returns {press event, new level}; len_n is the updated run length
   function automatic logic [1:0] deb_step(input logic s, input logic lvl, input int len,
                                           output int len_n);
      if (s == lvl) begin
         len_n = 0;
         return {1'b0, lvl};
      end
      if (len == DEB - 1) begin
         len_n = 0;
         return {!s, s};
      end
      len_n = len + 1;
      return {1'b0, lvl};
   endfunction

   function automatic model_t model_reset();
      model_t r;
      r.meta = 3'b111; r.sync = 3'b111; r.lvl = 2'b11;
      r.len0 = 0; r.len1 = 0; r.running = 1'b1; r.phase = 0; r.count = 0;
      r.e1 = 9'h000; r.e2 = 9'h0BF; r.ew = 1'b0;
      return r;
   endfunction

   function automatic model_t model_step(input model_t s, input logic [2:0] pins);
      model_t     n = s;
      logic [1:0] r;
      logic [1:0] c;
      bit         tk;
      r = deb_step(s.sync[0], s.lvl[0], s.len0, n.len0);
      c = deb_step(s.sync[1], s.lvl[1], s.len1, n.len1);
      n.lvl = {c[0], r[0]};
      n.e1 = (s.count / 10 == 0) ? 9'h000 : {2'b00, seg_tab[s.count / 10]};
      n.e2 = {1'b0, s.running, seg_tab[s.count % 10]};
      tk = s.running && (s.phase == CNT - 1);
      n.ew = 1'b0;
      if (c[1]) begin
         n.count = 0;
         n.phase = 0;
      end else if (tk) begin
         n.phase = 0;
         if (s.sync[2]) begin
            if (s.count == MAXV) begin n.count = 0; n.ew = 1'b1; end
            else n.count = s.count + 1;
         end else begin
            if (s.count == 0) begin n.count = MAXV; n.ew = 1'b1; end
            else n.count = s.count - 1;
         end
      end else if (s.running) begin
         n.phase = s.phase + 1;
      end
      if (r[1]) n.running = !s.running;
      n.sync = s.meta;
      n.meta = pins;
      return n;
   endfunction

   // reference model: one step per clock, expected outputs queued for the checker
   always @(posedge clk_in or negedge rst_n_in) begin : model_blk
      model_t nxt;
      if (!rst_n_in) begin
         m <= model_reset();
         sb.delete();
      end else begin
         nxt = model_step(m, {io.sw_dir, io.key_clr_n, io.key_run_n});
         m <= nxt;
         sb.push_back({nxt.e1, nxt.e2, nxt.ew});
      end
   end

   // per-cycle comparison of DUT outputs against the queued expectation
   always @(negedge clk_in) begin : check_blk
      logic [18:0] exp_v;
      if (!rst_n_in || sb.size() == 0) begin
         chk("reset_outputs", {io.segment_led_1, io.segment_led_2, io.wrap_pulse},
             {9'h000, 9'h0BF, 1'b0});
      end else begin
         exp_v = sb.pop_front();
         chk("cycle_outputs", {io.segment_led_1, io.segment_led_2, io.wrap_pulse}, exp_v);
      end
   end

   always @(negedge clk_in) begin
      if (io.wrap_pulse === 1'b1) wrap_seen <= wrap_seen + 1;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk_in);
      #1;
   endtask

   task automatic wait_state(input string name, input int cnt, input int ph, input int limit);
      int n = 0;
      while (!(m.count == cnt && (ph < 0 || m.phase == ph)) && n < limit) begin
         step(1);
         n++;
      end
      if (!(m.count == cnt && (ph < 0 || m.phase == ph))) begin
         total++;
         bad++;
         $display("FAIL %s: timeout after %0d cycles, count %0d required %0d", name, limit, m.count, cnt);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      vecs[0] = '{dir: 1'b1, target: 7,  led1: 9'h000, led2: 9'h087, wraps: 0};
      vecs[1] = '{dir: 1'b1, target: 12, led1: 9'h006, led2: 9'h0DB, wraps: 0};
      vecs[2] = '{dir: 1'b1, target: 0,  led1: 9'h000, led2: 9'h0BF, wraps: 1};
      vecs[3] = '{dir: 1'b0, target: 12, led1: 9'h006, led2: 9'h0DB, wraps: 1};
      vecs[4] = '{dir: 1'b0, target: 11, led1: 9'h006, led2: 9'h086, wraps: 0};
      vecs[5] = '{dir: 1'b0, target: 10, led1: 9'h006, led2: 9'h0BF, wraps: 0};
      vecs[6] = '{dir: 1'b0, target: 9,  led1: 9'h000, led2: 9'h0EF, wraps: 0};
      vecs[7] = '{dir: 1'b0, target: 5,  led1: 9'h000, led2: 9'h0ED, wraps: 0};

      io.key_run_n = 1'b1;
      io.key_clr_n = 1'b1;
      io.sw_dir    = 1'b1;
      step(3);
      chk("rst_led1", io.segment_led_1, 9'h000);
      chk("rst_led2", io.segment_led_2, 9'h0BF);
      chk("rst_wrap", io.wrap_pulse, 1'b0);
      rst_n_in = 1'b1;

      // counting up, wrapping, then counting down
      for (int i = 0; i < 8; i++) begin
         io.sw_dir = vecs[i].dir;
         w0 = wrap_seen;
         wait_state("vec_wait", vecs[i].target, -1, 200);
         step(1);
         chk("vec_led1", io.segment_led_1, vecs[i].led1);
         chk("vec_led2", io.segment_led_2, vecs[i].led2);
         chk("vec_wraps", wrap_seen - w0, vecs[i].wraps);
      end

      // clear event lands on the tick that would wrap 12 -> 0
      io.sw_dir = 1'b1;
      wait_state("clr_align", 11, 3, 400);
      w0 = wrap_seen;
      io.key_clr_n = 1'b0;
      step(5);
      chk("clr_at12_led1", io.segment_led_1, 9'h006);
      chk("clr_at12_led2", io.segment_led_2, 9'h0DB);
      step(1);
      chk("clr_zero_led1", io.segment_led_1, 9'h000);
      chk("clr_zero_led2", io.segment_led_2, 9'h0BF);
      io.key_clr_n = 1'b1;
      step(3);
      chk("clr_hold_led2", io.segment_led_2, 9'h0BF);
      step(1);
      chk("clr_restart_led2", io.segment_led_2, 9'h086);
      chk("clr_no_wrap", wrap_seen - w0, 0);

      // simultaneous clear and run press: cleared and paused
      io.key_run_n = 1'b0;
      io.key_clr_n = 1'b0;
      step(6);
      chk("pause_led1", io.segment_led_1, 9'h000);
      chk("pause_led2", io.segment_led_2, 9'h03F);
      io.key_run_n = 1'b1;
      io.key_clr_n = 1'b1;
      step(20);
      chk("pause_hold_led2", io.segment_led_2, 9'h03F);

      // resume: DP back on, first tick after a full prescaler period
      io.key_run_n = 1'b0;
      step(6);
      chk("resume_dp", io.segment_led_2, 9'h0BF);
      io.key_run_n = 1'b1;
      step(3);
      chk("resume_before_tick", io.segment_led_2, 9'h0BF);
      step(1);
      chk("resume_tick", io.segment_led_2, 9'h086);

      // a two-cycle glitch must not toggle run
      io.key_run_n = 1'b0;
      step(2);
      io.key_run_n = 1'b1;
      step(10);
      chk("glitch_dp", io.segment_led_2[8:7], 2'b01);

      // asynchronous reset mid-count
      wait_state("rst_align", 5, 2, 400);
      rst_n_in = 1'b0;
      #1;
      chk("async_rst_led1", io.segment_led_1, 9'h000);
      chk("async_rst_led2", io.segment_led_2, 9'h0BF);
      chk("async_rst_wrap", io.wrap_pulse, 1'b0);
      step(1);
      rst_n_in = 1'b1;
      step(4);
      chk("rst_restart_hold", io.segment_led_2, 9'h0BF);
      step(1);
      chk("rst_restart_tick", io.segment_led_2, 9'h086);
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/segment_counter_ctrl.md
SEGMENT_COUNTER_CTRL -- requirements
Module: segment_counter_ctrl

Interface
REQ-001 Parameter CNT_NUM, default 12_000_000, meaning clk_in cycles per count tick (≥2; 1 Hz at 12 MHz).
REQ-002 Parameter MAX_VAL, default 99, meaning terminal count, legal range 1..99.
REQ-003 Parameter DEB_NUM, default 240_000, meaning stable-level cycles required to accept a key change (20 ms at 12 MHz).
REQ-004 clk_in  input  1  system clock, rising edge.
REQ-005 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 key_run_n  input  1  pushbutton, active-low, asynchronous; each press toggles run/pause.
REQ-007 key_clr_n  input  1  pushbutton, active-low, asynchronous; each press clears count to 0.
REQ-008 sw_dir  input  1  direction level, asynchronous; 1 = up, 0 = down.
REQ-009 segment_led_1  output  9  tens digit, MSB~LSB = SEG,DP,G,F,E,D,C,B,A.
REQ-010 segment_led_2  output  9  units digit, same bit order.
REQ-011 wrap_pulse  output  1  one-cycle high on count wrap.

Function
REQ-012 Each of key_run_n, key_clr_n and sw_dir SHALL pass a 2-FF synchronizer before any use.
REQ-013 Each key SHALL be debounced: the debounced level changes only after the synchronized level differs from it for DEB_NUM consecutive cycles; any shorter glitch restarts the count and is ignored.
REQ-014 A press SHALL be a debounced 1->0 transition, producing exactly one single-cycle event; release produces no event.
REQ-015 Run flag: reset value 1; toggles on each run press.
REQ-016 Prescaler: counts 0..CNT_NUM-1 while running, wraps to 0; tick asserted in the cycle prescaler = CNT_NUM-1; when paused, the prescaler holds its value and no tick occurs.
REQ-017 Count: two BCD digits (tens, units) representing 0..MAX_VAL; no binary-to-BCD divider.
REQ-018 On tick with synchronized sw_dir=1: count+1; at MAX_VAL -> 0 and wrap_pulse=1 the next cycle.
REQ-019 On tick with sw_dir=0: count-1; at 0 -> MAX_VAL and wrap_pulse=1 the next cycle.
REQ-020 BCD carry/borrow: units 9->0 increments tens; units 0->9 decrements tens.
REQ-021 Clear press: count=0 and prescaler=0 in the same cycle; run flag unchanged; clear overrides a coincident tick; no wrap_pulse.
REQ-022 Direction change takes effect at the next tick; no count change and no prescaler reset.
REQ-023 Digit decode, 1 = segment lit, bits G..A: 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
REQ-024 Tens digit SHALL be blanked (G..A = 0) when tens = 0.
REQ-025 SEG bit SHALL be 0 on both outputs (digit enabled); DP of segment_led_1 = 0; DP of segment_led_2 = run flag.
REQ-026 Segment outputs SHALL be registered and reflect count and run state one cycle after they change.

Reset
REQ-027 Async assert of rst_n_in SHALL immediately force: count 0, prescaler 0, run=1, debouncers to released (1), wrap_pulse=0, segment_led_1=9'h000, segment_led_2=9'h0BF.
REQ-028 Reset assertion mid-count or mid-debounce SHALL abandon all state with no residual event after release.

Verification (CNT_NUM=4, DEB_NUM=3, MAX_VAL=12)
REQ-029 Release reset, sw_dir=1, keys high -> count advances every 4 cycles 0..12; at 7 led_2=9'h087, led_1=9'h000; at 12 led_1=9'h006, led_2=9'h0DB; next tick -> 0 with a single wrap_pulse.
REQ-030 sw_dir=0 from count 0 -> next tick gives 12 (led_1=9'h006, led_2=9'h0DB) and one wrap_pulse; then 11, 10, 9 (led_1=9'h000).
REQ-031 key_run_n low ≥6 cycles -> pause: count and prescaler frozen, led_2 DP=0 (count 0 -> 9'h03F); second press resumes, next tick after the remaining prescaler cycles.
REQ-032 key_run_n low pulse of 2 cycles -> no toggle, run flag and DP unchanged.
REQ-033 Clear press whose event coincides with a tick at count 12 -> count 0, no wrap_pulse, prescaler restarts at 0.
REQ-034 rst_n_in low for 1 cycle at count 5 with prescaler 2 -> outputs immediately 9'h000 / 9'h0BF; counting restarts from 0 with the full 4-cycle period.
